ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 9 +
 rtl/loader_valid_pipe.sv | 15 +
 rtl/ram_loader.sv | 108 ++++++++++
 tb/tb_ram_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared FSM encodings and legal read latencies for ram_loader
package ram_loader_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] VERIFY = 2'd2;
  localparam logic [1:0] CHECK = 2'd3;
  localparam int RL_COMB = 1;
  localparam int RL_REG = 2;
endpackage

// File: rtl/loader_valid_pipe.sv
// loader_valid_pipe: delays a read-issue flag by the memory read latency
module loader_valid_pipe
  import ram_loader_pkg::*;
#(
  parameter int DEPTH = RL_COMB
) (
  input  logic clock,
  input  logic reset_n,
  input  logic valid,
  output logic delayed
);
  logic [DEPTH-1:0] pipe;
  always_ff @(posedge clock) pipe <= !reset_n ? '0 : DEPTH'({pipe, valid});
  assign delayed = pipe[DEPTH-1];
endmodule

// File: rtl/ram_loader.sv
// ram_loader: streams words into a RAM, reads them back and compares checksums
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int READ_LATENCY = RL_COMB
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  error
);
  localparam int PIPE_DEPTH = READ_LATENCY == RL_REG ? RL_REG : RL_COMB;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [1:0] state;
  logic [ADDR_WIDTH:0] len, wcnt, rcnt, ccnt;
  logic [DATA_WIDTH-1:0] wsum, rsum;
  logic rd_issue, captured;
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  loader_valid_pipe #(.DEPTH(PIPE_DEPTH)) u_pipe (
    .clock(clock),
    .reset_n(reset_n),
    .valid(rd_issue),
    .delayed(captured)
  );
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      len <= '0;
      wcnt <= '0;
      rcnt <= '0;
      ccnt <= '0;
      wsum <= '0;
      rsum <= '0;
      rd_issue <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
      done <= 1'b0;
      pass <= 1'b0;
      error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pass <= 1'b0;
          error <= 1'b0;
          wsum <= '0;
          rsum <= '0;
          wcnt <= '0;
          rcnt <= '0;
          ccnt <= '0;
          len <= length;
          if (length == '0) begin
            done <= 1'b1;
            pass <= 1'b1;
          end else if (length > DEPTH) begin
            done <= 1'b1;
            error <= 1'b1;
          end else state <= LOAD;
        end
        LOAD: if (in_valid) begin
          wr_en <= 1'b1;
          wr_addr <= wcnt[ADDR_WIDTH-1:0];
          wr_data <= in_data;
          wsum <= wsum + in_data;
          wcnt <= wcnt + 1'b1;
          if (wcnt + 1'b1 == len) state <= VERIFY;
        end
        VERIFY: begin
          rd_issue <= rcnt != len;
          if (rcnt != len) begin
            rd_addr <= rcnt[ADDR_WIDTH-1:0];
            rcnt <= rcnt + 1'b1;
          end
          if (captured) begin
            rsum <= rsum + rd_data;
            ccnt <= ccnt + 1'b1;
            if (ccnt + 1'b1 == len) state <= CHECK;
          end
        end
        CHECK: begin
          done <= 1'b1;
          pass <= wsum == rsum;
          error <= wsum != rsum;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench driving READ_LATENCY 1 and 2 loaders side by side
module tb_ram_loader;
  logic clock = 0, reset_n = 0, start = 0, in_valid = 0, corrupt = 0;
  logic [4:0] length = 0;
  logic [7:0] in_data = 0;
  logic in_ready[2], wr_en[2], busy[2], done[2], pass[2], error[2];
  logic [3:0] wr_addr[2], rd_addr[2];
  logic [7:0] wr_data[2], rd_data[2];
  logic [11:0] exp_wr[2][$];
  logic [9:0] exp_res[2][$];
  logic [9:0] e;
  logic [1:0] exp_held = 0;
  logic chk_zero = 0, chk_drain = 0;
  int cyc = 0, start_cyc = 0, tests = 0, fails = 0;
  logic [7:0] words[16];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : lane
    logic [7:0] mem[16];
    logic [7:0] q1 = 0, q2 = 0;
    ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(g + 1)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .length(length),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .rd_addr(rd_addr[g]), .rd_data(rd_data[g]), .busy(busy[g]),
      .done(done[g]), .pass(pass[g]), .error(error[g])
    );
    always @(posedge clock) begin
      if (wr_en[g]) mem[wr_addr[g]] <= wr_data[g] + {7'd0, corrupt && wr_addr[g] == 4'd2};
      q1 <= mem[rd_addr[g]];
      q2 <= q1;
    end
    assign rd_data[g] = g == 0 ? q1 : q2;
  end
  task automatic check(input int l, input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL lane%0d %s: got %0h, expected %0h", l + 1, name, got, want);
    end
  endtask
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        check(i, "write_expected", int'(exp_wr[i].size() != 0), 1);
        if (exp_wr[i].size() != 0) check(i, "write_addr_data", int'({wr_addr[i], wr_data[i]}), int'(exp_wr[i].pop_front()));
      end
      if (done[i]) begin
        check(i, "done_expected", int'(exp_res[i].size() != 0), 1);
        if (exp_res[i].size() != 0) begin
          e = exp_res[i].pop_front();
          check(i, "pass_error", int'({pass[i], error[i]}), int'(e[9:8]));
          if (e[7:0] != 0) check(i, "done_latency", cyc - start_cyc, int'(e[7:0]));
        end
      end
      if (chk_zero) check(i, "reset_outputs", int'({in_ready[i], wr_en[i], busy[i], done[i], pass[i], error[i], wr_addr[i], wr_data[i], rd_addr[i]}), 0);
      if (chk_drain) begin
        check(i, "writes_left", exp_wr[i].size(), 0);
        check(i, "dones_left", exp_res[i].size(), 0);
        check(i, "held_flags", int'({pass[i], error[i]}), int'(exp_held));
      end
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drain();
    chk_drain = 1;
    tick();
    chk_drain = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) begin
      $display("FAIL timeout: busy still high after 200 cycles, expected idle");
      $fatal(1, "timeout");
    end
    tick();
    tick();
    drain();
  endtask
  task automatic run(input logic [4:0] len, input bit gap, input bit bad, input logic [1:0] res, input logic [7:0] lat1, input logic [7:0] lat2);
    corrupt = bad;
    exp_held = res;
    exp_res[0].push_back({res, lat1});
    exp_res[1].push_back({res, lat2});
    start = 1;
    length = len;
    start_cyc = cyc;
    tick();
    start = 0;
    if (len != 0 && len <= 16) for (int k = 0; k < int'(len); k++) begin
      if (gap) begin
        in_valid = 0;
        in_data = 8'hEE;
        tick();
      end
      in_valid = 1;
      in_data = words[k];
      for (int i = 0; i < 2; i++) exp_wr[i].push_back({4'(k), words[k]});
      tick();
    end
    in_valid = 0;
    wait_idle();
  endtask
  initial begin
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
    tick();
    chk_zero = 1;
    tick();
    chk_zero = 0;
    reset_n = 1;
    tick();
    run(5'd4, 0, 0, 2'b10, 8'd12, 8'd13);
    run(5'd4, 0, 1, 2'b01, 8'd12, 8'd13);
    for (int k = 0; k < 16; k++) words[k] = 8'(k * 17 + 5);
    run(5'd16, 1, 0, 2'b10, 8'd0, 8'd0);
    run(5'd0, 0, 0, 2'b10, 8'd1, 8'd1);
    run(5'd17, 0, 0, 2'b01, 8'd1, 8'd1);
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
    exp_held = 2'b00;
    start = 1;
    length = 5'd4;
    tick();
    start = 0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1;
      in_data = words[k];
      for (int i = 0; i < 2; i++) exp_wr[i].push_back({4'(k), words[k]});
      tick();
    end
    in_valid = 0;
    reset_n = 0;
    tick();
    reset_n = 1;
    chk_zero = 1;
    tick();
    chk_zero = 0;
    repeat (20) tick();
    drain();
    run(5'd4, 0, 0, 2'b10, 8'd12, 8'd13);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
